merge_heads_stream: RTL and testbench

Streaming successor to the combinational multi-head merge op: accepts per-head attention outputs one head-slice per beat in head-major order (all tokens of head 0, then head 1, …) and re-emits them token-major (token 0 heads 0..num-1, token 1 …), so the downstream projection sees each token's concatenated `num*HEAD_DIM` row as consecutive beats. The active head count is a runtime input sampled per frame. The block sits between the attention-output stage and the output linear layer, and uses valid/ready on both sides with a single frame buffer.

---
 rtl/merge_heads_stream.sv | 270 +++++++++++++++++++++++++++
 tb/tb_merge_heads_stream.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_heads_stream.sv
// ---------------------------------------------------------------------------
// merge_heads_stream
//
// Streaming head-merge stage placed between the attention-output stage and
// the output projection. Attention outputs arrive head-major (every token of
// head 0, then every token of head 1, ...). They are written into a single
// frame buffer and then read back token-major (token 0 heads 0..nh-1,
// token 1 heads 0..nh-1, ...). The projection therefore receives each
// token's concatenated row as consecutive beats.
//
// Input and output never overlap. A frame is filled completely, then drained
// completely, and only after that is the next frame accepted.
//
// Ports
//   clk_p          : single clock, rising edge
//   rst            : synchronous active-high reset, abandons any frame
//   num            : requested head count, sampled on a frame's first beat
//   in_data        : one head slice (HEAD_DIM elements, element 0 in LSBs)
//   in_valid       : upstream beat valid
//   in_ready       : this block accepts a beat (IDLE or FILL)
//   out_data       : merged head slice
//   out_valid      : output beat valid
//   out_ready      : downstream accepts the beat
//   out_last_head  : beat is the last head of its token
//   out_last       : beat is the last beat of the frame
//   busy           : a frame is in FILL or DRAIN
//   cfg_err        : one-cycle pulse when the sampled num was out of range
// ---------------------------------------------------------------------------
module merge_heads_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int SEQ_LEN    = 128,
   parameter int HEAD_NUM   = 12,
   parameter int HEAD_DIM   = 64,
   parameter int NUM_WIDTH  = 3
) (
   input  logic                           clk_p,
   input  logic                           rst,
   input  logic [NUM_WIDTH:0]             num,
   input  logic [DATA_WIDTH*HEAD_DIM-1:0] in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [DATA_WIDTH*HEAD_DIM-1:0] out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last_head,
   output logic                           out_last,
   output logic                           busy,
   output logic                           cfg_err
);

   localparam int W     = DATA_WIDTH * HEAD_DIM;
   localparam int DEPTH = SEQ_LEN * HEAD_NUM;
   localparam int AW    = (DEPTH > 1)   ? $clog2(DEPTH)   : 1;
   localparam int TW    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   // Head counters and nh share one width so that nh itself (up to HEAD_NUM)
   // is representable, not just the largest head index.
   localparam int HNW   = $clog2(HEAD_NUM + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;

   logic [HNW-1:0]   nh_q, nh_d;
   logic [TW-1:0]    t_in_q, t_in_d;
   logic [HNW-1:0]   h_in_q, h_in_d;
   logic [TW-1:0]    t_out_q, t_out_d;
   logic [HNW-1:0]   h_out_q, h_out_d;
   logic             rd_done_q, rd_done_d;

   logic [W-1:0]     out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_head_q, out_last_head_d;
   logic             out_last_q, out_last_d;
   logic             cfg_err_q, cfg_err_d;

   logic             num_ok;
   logic [HNW-1:0]   nh_num;
   logic [HNW-1:0]   nh_eff;
   logic             in_fire;
   logic             out_fire;
   logic             fill_last;
   logic             load;
   logic             rd_last_head;
   logic             rd_last;
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    rd_addr;

   logic [W-1:0]     mem_q [DEPTH];

   // Frame buffer storage. Entries are never cleared: reset and frame
   // boundaries only rewind the counters, and every entry read in a frame
   // was written earlier in that same frame.
   always_ff @(posedge clk_p) begin
      if (in_fire) begin
         mem_q[wr_addr] <= in_data;
      end
   end

   // State register: the only place the FSM state changes.
   always_ff @(posedge clk_p) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A frame of exactly one beat skips FILL entirely.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (in_fire) begin
               state_d = fill_last ? DRAIN : FILL;
            end
         end
         FILL: begin
            if (fill_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_fire && out_last_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs. in_ready is also held low during reset so that upstream
   // never believes a beat was taken while the block is clearing.
   always_comb begin
      in_ready = !rst && (state_q != DRAIN);
      busy     = (state_q != IDLE);
   end

   // Head-count resolution and input-side bookkeeping.
   // While IDLE the frame's nh is not registered yet, so the value decoded
   // straight from num is used; this lets the very first beat already know
   // whether it is also the last beat of the frame.
   always_comb begin
      num_ok  = (num != '0) && (int'(num) <= HEAD_NUM);
      nh_num  = num_ok ? HNW'(num) : HNW'(HEAD_NUM);
      nh_eff  = (state_q == IDLE) ? nh_num : nh_q;

      in_fire   = in_valid && in_ready;
      fill_last = in_fire
                  && (t_in_q == TW'(SEQ_LEN - 1))
                  && (h_in_q == nh_eff - HNW'(1));

      // Head-major layout: each head owns a contiguous SEQ_LEN block.
      wr_addr = AW'(h_in_q) * AW'(SEQ_LEN) + AW'(t_in_q);

      nh_d      = nh_q;
      cfg_err_d = 1'b0;
      if ((state_q == IDLE) && in_fire) begin
         nh_d      = nh_num;
         cfg_err_d = !num_ok;
      end

      // Token is the inner counter on the way in. Both counters wrap back
      // to zero on the final beat, so the next frame starts at address 0.
      t_in_d = t_in_q;
      h_in_d = h_in_q;
      if (in_fire) begin
         if (t_in_q == TW'(SEQ_LEN - 1)) begin
            t_in_d = '0;
            if (h_in_q == nh_eff - HNW'(1)) begin
               h_in_d = '0;
            end else begin
               h_in_d = h_in_q + HNW'(1);
            end
         end else begin
            t_in_d = t_in_q + TW'(1);
         end
      end
   end

   // Output side. The buffer read lands directly in the output register,
   // which is reloaded whenever it is empty or being consumed. That gives
   // the two-cycle start latency (enter DRAIN, then read) and no bubbles
   // while out_ready stays high. A stalled beat simply keeps the register
   // untouched, which holds data and flags stable.
   always_comb begin
      out_fire = out_valid_q && out_ready;
      load     = (state_q == DRAIN) && !rd_done_q && (!out_valid_q || out_ready);

      // Token-major read: head is the inner counter on the way out.
      rd_addr      = AW'(h_out_q) * AW'(SEQ_LEN) + AW'(t_out_q);
      rd_last_head = (h_out_q == nh_q - HNW'(1));
      rd_last      = rd_last_head && (t_out_q == TW'(SEQ_LEN - 1));

      out_data_d      = out_data_q;
      out_last_head_d = out_last_head_q;
      out_last_d      = out_last_q;
      out_valid_d     = out_valid_q && !out_ready;
      h_out_d         = h_out_q;
      t_out_d         = t_out_q;

      if (load) begin
         out_data_d      = mem_q[rd_addr];
         out_last_head_d = rd_last_head;
         out_last_d      = rd_last;
         out_valid_d     = 1'b1;
         if (rd_last_head) begin
            h_out_d = '0;
            if (t_out_q == TW'(SEQ_LEN - 1)) begin
               t_out_d = '0;
            end else begin
               t_out_d = t_out_q + TW'(1);
            end
         end else begin
            h_out_d = h_out_q + HNW'(1);
         end
      end

      // rd_done marks that the final beat has been fetched, so the register
      // is not reloaded while that beat waits for out_ready. It only means
      // something inside DRAIN and is cleared as soon as the frame ends.
      if (state_q != DRAIN) begin
         rd_done_d = 1'b0;
      end else if (load && rd_last) begin
         rd_done_d = 1'b1;
      end else begin
         rd_done_d = rd_done_q;
      end
   end

   // Datapath and counter registers, all cleared by reset so that an
   // abandoned frame leaves nothing behind that could reach the output.
   always_ff @(posedge clk_p) begin
      if (rst) begin
         nh_q            <= '0;
         t_in_q          <= '0;
         h_in_q          <= '0;
         t_out_q         <= '0;
         h_out_q         <= '0;
         rd_done_q       <= 1'b0;
         out_data_q      <= '0;
         out_valid_q     <= 1'b0;
         out_last_head_q <= 1'b0;
         out_last_q      <= 1'b0;
         cfg_err_q       <= 1'b0;
      end else begin
         nh_q            <= nh_d;
         t_in_q          <= t_in_d;
         h_in_q          <= h_in_d;
         t_out_q         <= t_out_d;
         h_out_q         <= h_out_d;
         rd_done_q       <= rd_done_d;
         out_data_q      <= out_data_d;
         out_valid_q     <= out_valid_d;
         out_last_head_q <= out_last_head_d;
         out_last_q      <= out_last_d;
         cfg_err_q       <= cfg_err_d;
      end
   end

   assign out_data      = out_data_q;
   assign out_valid     = out_valid_q;
   assign out_last_head = out_last_head_q;
   assign out_last      = out_last_q;
   assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_merge_heads_stream.sv
// ---------------------------------------------------------------------------
// tb_merge_heads_stream
//
// Directed bench for merge_heads_stream with a small configuration
// (SEQ_LEN=4, HEAD_NUM=3, HEAD_DIM=2, DATA_WIDTH=8). Every input beat is
// tagged: element 1 = {frame id, head}, element 0 = token. Expected output
// order, flags and timing are worked out here from those tags.
// ---------------------------------------------------------------------------
module tb_merge_heads_stream;

   localparam int SEQ  = 4;
   localparam int HMAX = 3;
   localparam int DW   = 8;
   localparam int HD   = 2;
   localparam int NW   = 3;

   typedef struct packed {
      logic        lh;
      logic        last;
      logic [15:0] data;
   } beat_t;

   logic              clk_p = 1'b0;
   logic              rst;
   logic [NW:0]       num;
   logic [DW*HD-1:0]  in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DW*HD-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last_head;
   logic              out_last;
   logic              busy;
   logic              cfg_err;

   int     tests = 0;
   int     fails = 0;
   int     cyc = 0;
   int     firstFireCycle = -1;
   int     lastFireCycle = -1;
   int     firstValidCycle = -1;
   int     lastOutFireCycle = -1;
   int     lastCount = 0;
   int     cfgErrCount = 0;
   int     errBase = 0;
   beat_t  outQ[$];
   logic   prevStall = 1'b0;
   logic [15:0] prevData = '0;
   logic [1:0]  prevFlags = '0;

   merge_heads_stream #(
      .DATA_WIDTH (DW),
      .SEQ_LEN    (SEQ),
      .HEAD_NUM   (HMAX),
      .HEAD_DIM   (HD),
      .NUM_WIDTH  (NW)
   ) dut (
      .clk_p         (clk_p),
      .rst           (rst),
      .num           (num),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_last_head (out_last_head),
      .out_last      (out_last),
      .busy          (busy),
      .cfg_err       (cfg_err)
   );

   // 10 ns clock.
   always #5 clk_p = ~clk_p;

   // Cycle counter used to measure latencies between handshakes.
   always @(posedge clk_p) begin
      cyc <= cyc + 1;
   end

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Output monitor, sampled on the falling edge so every value is settled
   // for the next rising edge. It records accepted beats, counts cfg_err
   // pulses, checks that a stalled beat is held unchanged, and checks that
   // input is never ready while output is pending.
   always @(negedge clk_p) begin
      if (rst) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("stall_data", {16'b0, out_data}, {16'b0, prevData});
            checkOutput("stall_flags", {30'b0, out_last_head, out_last}, {30'b0, prevFlags});
         end
         if (out_valid) begin
            checkOutput("no_overlap_in_ready", {31'b0, in_ready}, 32'd0);
            if (firstValidCycle < 0) firstValidCycle = cyc;
         end
         if (cfg_err) cfgErrCount++;
         if (out_valid && out_ready) begin
            outQ.push_back('{lh: out_last_head, last: out_last, data: out_data});
            if (out_last) begin
               lastCount++;
               lastOutFireCycle = cyc;
            end
         end
         prevStall = out_valid && !out_ready;
         prevData  = out_data;
         prevFlags = {out_last_head, out_last};
      end
   end

   // Safety net so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Present one beat and hold it until accepted (bounded wait).
   task automatic pushBeat(input logic [15:0] d, input logic [NW:0] n);
      int guard;
      guard = 0;
      in_data  = d;
      num      = n;
      in_valid = 1'b1;
      @(negedge clk_p);
      while (!in_ready && guard < 200) begin
         @(negedge clk_p);
         guard++;
      end
      if (guard >= 200) checkOutput("in_ready_timeout", guard, 32'd0);
      lastFireCycle = cyc;
      if (firstFireCycle < 0) firstFireCycle = cyc;
      @(posedge clk_p);
      #1;
      in_valid = 1'b0;
   endtask

   // Push a whole head-major frame; optionally insert idle gaps.
   task automatic applyStimulus(input int frameId, input logic [NW:0] n,
                                input int nh, input bit gaps, input bit expErr);
      for (int h = 0; h < nh; h++) begin
         for (int t = 0; t < SEQ; t++) begin
            pushBeat({frameId[3:0], h[3:0], t[7:0]}, n);
            if (h == 0 && t == 0) begin
               checkOutput($sformatf("f%0d_cfg_err_pulse", frameId), {31'b0, cfg_err}, {31'b0, expErr});
               checkOutput($sformatf("f%0d_busy_after_first", frameId), {31'b0, busy}, 32'd1);
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
               repeat ($urandom_range(1, 2)) @(posedge clk_p);
               #1;
            end
         end
      end
   endtask

   // Run the output side until one more out_last fire (bounded).
   task automatic drainFrame(input bit randomReady);
      int guard;
      int target;
      guard  = 0;
      target = lastCount + 1;
      while (lastCount < target && guard < 400) begin
         out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk_p);
         #1;
         guard++;
      end
      out_ready = 1'b1;
      checkOutput("drain_done", lastCount, target);
   endtask

   // Pop one frame's beats and compare against the token-major order.
   task automatic checkFrame(input int frameId, input int nh);
      beat_t b;
      int h;
      int t;
      for (int i = 0; i < nh * SEQ && outQ.size() > 0; i++) begin
         b = outQ.pop_front();
         h = i % nh;
         t = i / nh;
         checkOutput($sformatf("f%0d_beat%0d", frameId, i), {14'b0, b},
                     {14'b0, (h == nh - 1), (i == nh * SEQ - 1), frameId[3:0], h[3:0], t[7:0]});
      end
   endtask

   task automatic resetTracking();
      firstFireCycle  = -1;
      firstValidCycle = -1;
      outQ.delete();
      errBase = cfgErrCount;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
      checkOutput({tag, "_out_data"}, {16'b0, out_data}, 32'd0);
      checkOutput({tag, "_out_last_head"}, {31'b0, out_last_head}, 32'd0);
      checkOutput({tag, "_out_last"}, {31'b0, out_last}, 32'd0);
      checkOutput({tag, "_cfg_err"}, {31'b0, cfg_err}, 32'd0);
      checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
   endtask

   // Directed sequence.
   initial begin
      rst       = 1'b1;
      num       = '0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk_p);
      #1;
      checkResetValues("reset");
      rst = 1'b0;
      @(negedge clk_p);
      checkOutput("in_ready_after_reset", {31'b0, in_ready}, 32'd1);
      @(posedge clk_p);
      #1;

      // Full frame, all three heads, no backpressure.
      $display("[TB] full frame num=3");
      out_ready = 1'b1;
      resetTracking();
      applyStimulus(1, 4'd3, 3, 1'b0, 1'b0);
      drainFrame(1'b0);
      checkOutput("f1_latency", firstValidCycle - lastFireCycle, 32'd2);
      checkOutput("f1_throughput", lastOutFireCycle - firstValidCycle, 32'd11);
      checkOutput("f1_busy_end", {31'b0, busy}, 32'd0);
      checkOutput("f1_in_ready_end", {31'b0, in_ready}, 32'd1);
      checkOutput("f1_len", outQ.size(), 32'd12);
      checkOutput("f1_cfg_count", cfgErrCount - errBase, 32'd0);
      checkFrame(1, 3);

      // Partial heads.
      $display("[TB] partial frame num=2");
      resetTracking();
      applyStimulus(2, 4'd2, 2, 1'b0, 1'b0);
      drainFrame(1'b0);
      checkOutput("f2_latency", firstValidCycle - lastFireCycle, 32'd2);
      checkOutput("f2_len", outQ.size(), 32'd8);
      checkFrame(2, 2);

      // Out-of-range head counts fall back to three heads.
      $display("[TB] illegal num=0 and num=7");
      resetTracking();
      applyStimulus(3, 4'd0, 3, 1'b0, 1'b1);
      drainFrame(1'b0);
      checkOutput("f3_cfg_count", cfgErrCount - errBase, 32'd1);
      checkOutput("f3_len", outQ.size(), 32'd12);
      checkFrame(3, 3);
      resetTracking();
      applyStimulus(4, 4'd7, 3, 1'b0, 1'b1);
      drainFrame(1'b0);
      checkOutput("f4_cfg_count", cfgErrCount - errBase, 32'd1);
      checkOutput("f4_len", outQ.size(), 32'd12);
      checkFrame(4, 3);

      // Random input gaps and random output backpressure.
      $display("[TB] backpressure");
      resetTracking();
      applyStimulus(6, 4'd3, 3, 1'b1, 1'b0);
      drainFrame(1'b1);
      checkOutput("f6_len", outQ.size(), 32'd12);
      checkFrame(6, 3);

      // Reset after five input beats, then a fresh frame.
      $display("[TB] reset mid-frame");
      resetTracking();
      for (int k = 0; k < 5; k++) begin
         pushBeat({4'd7, 4'(k / SEQ), 8'(k % SEQ)}, 4'd3);
      end
      rst = 1'b1;
      @(posedge clk_p);
      #1;
      checkResetValues("midreset");
      rst = 1'b0;
      repeat (3) @(posedge clk_p);
      #1;
      checkOutput("no_output_after_reset", outQ.size(), 32'd0);
      resetTracking();
      applyStimulus(8, 4'd3, 3, 1'b0, 1'b0);
      drainFrame(1'b0);
      checkOutput("f8_len", outQ.size(), 32'd12);
      checkFrame(8, 3);

      // Back-to-back frames: B waits until A's final beat is taken.
      $display("[TB] back-to-back frames");
      resetTracking();
      applyStimulus(9, 4'd3, 3, 1'b0, 1'b0);
      firstFireCycle = -1;
      applyStimulus(10, 4'd3, 3, 1'b0, 1'b0);
      checkOutput("b2b_accept_gap", firstFireCycle - lastOutFireCycle, 32'd1);
      drainFrame(1'b0);
      checkOutput("b2b_len", outQ.size(), 32'd24);
      checkFrame(9, 3);
      checkFrame(10, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
